// File: rtl/chess_clock_pkg.sv
// Shared types and defaults for the two-player chess clock.
// Latency: n/a (declarations only).
// Backpressure: n/a; all inputs are single-cycle pulses, nothing is ever stalled.
package chess_clock_pkg;

  // Controller states; values are fixed so debug taps read consistently.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN_A  = 3'd1,
    ST_RUN_B  = 3'd2,
    ST_PAUSED = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  localparam int DEF_TIME_W   = 12;
  localparam int DEF_INIT_SEC = 300;
  localparam int DEF_INC_SEC  = 0;

endpackage

// File: rtl/chess_timer.sv
// One player's countdown register with saturating increment and zero detect.
// Latency: 1 cycle from load/dec/inc to o_time; o_zero is combinational off dec.
// Backpressure: none; every dec/inc/load pulse is applied in the cycle it is seen.
module chess_timer
  import chess_clock_pkg::*;
#(
  parameter int TIME_W   = DEF_TIME_W,
  parameter int INIT_SEC = DEF_INIT_SEC,
  parameter int INC_SEC  = DEF_INC_SEC
) (
  input  logic              i_clk,
  input  logic              i_load,
  input  logic              i_dec,
  input  logic              i_inc,
  output logic [TIME_W-1:0] o_time,
  output logic              o_zero
);

  localparam logic [TIME_W-1:0] INIT_V = TIME_W'(INIT_SEC);
  localparam logic [TIME_W:0]   INC_V  = (TIME_W+1)'(INC_SEC);

  logic [TIME_W-1:0] r_time;
  logic [TIME_W-1:0] w_dec_val;
  logic [TIME_W:0]   w_sum;

  // Decrement never wraps below zero; a dec at zero simply holds.
  assign w_dec_val = (i_dec && (r_time != '0)) ? (r_time - TIME_W'(1)) : r_time;
  // Zero is reported only for a tick that lands on zero, so the FSM can flag that same cycle.
  assign o_zero    = i_dec && (w_dec_val == '0);
  // Increment is taken on the post-decrement value; the carry bit signals saturation.
  assign w_sum     = {1'b0, w_dec_val} + INC_V;
  assign o_time    = r_time;

  // Register update: load wins, then increment (which already includes any tick), else tick.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_time <= INIT_V;
    end else if (i_inc) begin
      r_time <= w_sum[TIME_W] ? {TIME_W{1'b1}} : w_sum[TIME_W-1:0];
    end else begin
      r_time <= w_dec_val;
    end
  end

endmodule

// File: rtl/chess_clock_ctrl.sv
// Chess clock controller: routes the 1 Hz tick to the mover's timer, handles turns, pause, flags.
// Latency: 1 cycle from any input pulse to the registered outputs.
// Backpressure: none; back-to-back pulses are each honoured, ignored inputs are dropped.
module chess_clock_ctrl
  import chess_clock_pkg::*;
#(
  parameter int TIME_W   = DEF_TIME_W,
  parameter int INIT_SEC = DEF_INIT_SEC,
  parameter int INC_SEC  = DEF_INC_SEC
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_ce,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_new,
  input  logic              i_btn_a,
  input  logic              i_btn_b,
  output logic [TIME_W-1:0] o_time_a,
  output logic [TIME_W-1:0] o_time_b,
  output logic              o_active,
  output logic              o_run,
  output logic              o_flag_a,
  output logic              o_flag_b
);

  state_t r_state;
  logic   r_active;
  logic   r_run;
  logic   r_flag_a;
  logic   r_flag_b;

  logic w_run_a;
  logic w_run_b;
  logic w_zero_a;
  logic w_zero_b;
  logic w_reload;
  logic w_load;
  logic w_dec_a;
  logic w_dec_b;
  logic w_inc_a;
  logic w_inc_b;

  assign w_run_a  = (r_state == ST_RUN_A);
  assign w_run_b  = (r_state == ST_RUN_B);
  // NEW reloads only from PAUSED (when START is not also present) or OVER.
  assign w_reload = i_new && (((r_state == ST_PAUSED) && !i_start) || (r_state == ST_OVER));
  assign w_load   = i_clr || w_reload;
  assign w_dec_a  = w_run_a && i_ce;
  assign w_dec_b  = w_run_b && i_ce;
  // A turn-end earns the increment only if this cycle neither flagged nor paused.
  assign w_inc_a  = w_run_a && i_btn_a && !w_zero_a && !i_pause;
  assign w_inc_b  = w_run_b && i_btn_b && !w_zero_b && !i_pause;

  chess_timer #(.TIME_W(TIME_W), .INIT_SEC(INIT_SEC), .INC_SEC(INC_SEC)) u_timer_a (
    .i_clk  (i_clk),
    .i_load (w_load),
    .i_dec  (w_dec_a),
    .i_inc  (w_inc_a),
    .o_time (o_time_a),
    .o_zero (w_zero_a)
  );

  chess_timer #(.TIME_W(TIME_W), .INIT_SEC(INIT_SEC), .INC_SEC(INC_SEC)) u_timer_b (
    .i_clk  (i_clk),
    .i_load (w_load),
    .i_dec  (w_dec_b),
    .i_inc  (w_inc_b),
    .o_time (o_time_b),
    .o_zero (w_zero_b)
  );

  // Game sequencing with registered RUN/ACTIVE/flag outputs; flag fall outranks pause and buttons.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state  <= ST_IDLE;
      r_active <= 1'b0;
      r_run    <= 1'b0;
      r_flag_a <= 1'b0;
      r_flag_b <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_RUN_A;
            r_run   <= 1'b1;
          end
        end
        ST_RUN_A: begin
          if (w_zero_a) begin
            r_flag_a <= 1'b1;
            r_state  <= ST_OVER;
            r_run    <= 1'b0;
          end else if (i_pause) begin
            r_state <= ST_PAUSED;
            r_run   <= 1'b0;
          end else if (i_btn_a) begin
            r_state  <= ST_RUN_B;
            r_active <= 1'b1;
          end
        end
        ST_RUN_B: begin
          if (w_zero_b) begin
            r_flag_b <= 1'b1;
            r_state  <= ST_OVER;
            r_run    <= 1'b0;
          end else if (i_pause) begin
            r_state <= ST_PAUSED;
            r_run   <= 1'b0;
          end else if (i_btn_b) begin
            r_state  <= ST_RUN_A;
            r_active <= 1'b0;
          end
        end
        ST_PAUSED: begin
          if (i_start) begin
            r_state <= r_active ? ST_RUN_B : ST_RUN_A;
            r_run   <= 1'b1;
          end else if (i_new) begin
            r_state  <= ST_IDLE;
            r_active <= 1'b0;
          end
        end
        ST_OVER: begin
          if (i_new) begin
            r_state  <= ST_IDLE;
            r_active <= 1'b0;
            r_flag_a <= 1'b0;
            r_flag_b <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_run   <= 1'b0;
        end
      endcase
    end
  end

  assign o_active = r_active;
  assign o_run    = r_run;
  assign o_flag_a = r_flag_a;
  assign o_flag_b = r_flag_b;

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Bench for chess_clock_ctrl: directed game scenarios plus random pulses against a game-level model.
// Latency: outputs checked 1 ns after each rising edge.
// Backpressure: n/a.
module tb_chess_clock_ctrl;

  localparam int TW   = 4;
  localparam int INIT = 5;
  localparam int INC  = 2;
  localparam int TMAX = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          i_clr = 1'b0, i_ce = 1'b0, i_start = 1'b0, i_pause = 1'b0;
  logic          i_new = 1'b0, i_btn_a = 1'b0, i_btn_b = 1'b0;
  logic [TW-1:0] o_time_a, o_time_b;
  logic          o_active, o_run, o_flag_a, o_flag_b;

  int n_checks = 0;
  int n_errors = 0;

  // Game-level model: a mode plus who is on move, not a per-player state machine.
  localparam int M_IDLE = 0, M_PLAY = 1, M_HOLD = 2, M_DONE = 3;
  int m_mode;
  int m_t[2];
  int m_act;
  int m_flag[2];

  chess_clock_ctrl #(.TIME_W(TW), .INIT_SEC(INIT), .INC_SEC(INC)) dut (
    .i_clk    (clk),
    .i_clr    (i_clr),
    .i_ce     (i_ce),
    .i_start  (i_start),
    .i_pause  (i_pause),
    .i_new    (i_new),
    .i_btn_a  (i_btn_a),
    .i_btn_b  (i_btn_b),
    .o_time_a (o_time_a),
    .o_time_b (o_time_b),
    .o_active (o_active),
    .o_run    (o_run),
    .o_flag_a (o_flag_a),
    .o_flag_b (o_flag_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reload();
    m_t[0] = INIT; m_t[1] = INIT; m_act = 0;
    m_flag[0] = 0; m_flag[1] = 0; m_mode = M_IDLE;
  endfunction

  function automatic void m_step(input bit clr, ce, start, pause, nw, ba, bb);
    int p;
    int t;
    bit btn;
    if (clr) begin
      m_reload();
      return;
    end
    case (m_mode)
      M_IDLE: if (start) m_mode = M_PLAY;
      M_PLAY: begin
        p   = m_act;
        t   = m_t[p];
        btn = (p == 0) ? ba : bb;
        if (ce) t = (t > 0) ? t - 1 : 0;
        if (ce && t == 0) begin
          m_flag[p] = 1;
          m_mode    = M_DONE;
        end else if (pause) begin
          m_mode = M_HOLD;
        end else if (btn) begin
          t     = (t + INC > TMAX) ? TMAX : t + INC;
          m_act = 1 - p;
        end
        m_t[p] = t;
      end
      M_HOLD: begin
        if (start)   m_mode = M_PLAY;
        else if (nw) m_reload();
      end
      default: if (nw) m_reload();
    endcase
  endfunction

  // Apply one cycle of pulses, advance the model, then compare every output after the edge.
  task automatic step(input bit clr, ce, start, pause, nw, ba, bb);
    i_clr = clr; i_ce = ce; i_start = start; i_pause = pause;
    i_new = nw; i_btn_a = ba; i_btn_b = bb;
    m_step(clr, ce, start, pause, nw, ba, bb);
    @(posedge clk);
    #1;
    chk("time_a", int'(o_time_a), m_t[0]);
    chk("time_b", int'(o_time_b), m_t[1]);
    chk("active", int'(o_active), m_act);
    chk("run",    int'(o_run), (m_mode == M_PLAY) ? 1 : 0);
    chk("flag_a", int'(o_flag_a), m_flag[0]);
    chk("flag_b", int'(o_flag_b), m_flag[1]);
    i_clr = 0; i_ce = 0; i_start = 0; i_pause = 0;
    i_new = 0; i_btn_a = 0; i_btn_b = 0;
  endtask

  // Tick in the style of the prescaler: one CE followed by three quiet cycles.
  task automatic tick();
    step(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_reload();
    // Reset state.
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_ta", int'(o_time_a), 5);
    chk("rst_run", int'(o_run), 0);

    // Reset mid-run with TIME_B = 3.
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    tick(); tick();
    chk("midrun_tb", int'(o_time_b), 3);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("midrun_clr_tb", int'(o_time_b), 5);
    chk("midrun_clr_act", int'(o_active), 0);
    chk("midrun_clr_run", int'(o_run), 0);

    // Basic turn: 5 - 2 + 2 = 5, then B loses one second.
    step(0, 0, 1, 0, 0, 0, 0);
    tick(); tick();
    step(0, 0, 0, 0, 0, 1, 0);
    chk("turn_ta", int'(o_time_a), 5);
    chk("turn_act", int'(o_active), 1);
    tick();
    chk("turn_tb", int'(o_time_b), 4);

    // Pause and resume in RUN_B.
    step(0, 0, 0, 1, 0, 0, 0);
    tick(); tick(); tick();
    chk("pause_tb", int'(o_time_b), 4);
    step(0, 0, 1, 1, 0, 0, 0);
    chk("resume_run", int'(o_run), 1);
    chk("resume_act", int'(o_active), 1);
    tick();
    chk("resume_tb", int'(o_time_b), 3);

    // Hand back to A, burn A down to 1, then CE together with BTN_A.
    step(0, 0, 0, 0, 0, 0, 1);
    tick(); tick(); tick(); tick();
    chk("pre_flag_ta", int'(o_time_a), 1);
    step(0, 1, 0, 0, 0, 1, 0);
    chk("flag_ta", int'(o_time_a), 0);
    chk("flag_fa", int'(o_flag_a), 1);
    chk("flag_tb", int'(o_time_b), 5);
    chk("flag_run", int'(o_run), 0);

    // Game over: START and buttons do nothing, NEW restarts.
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("over_fa", int'(o_flag_a), 1);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("new_fa", int'(o_flag_a), 0);
    chk("new_ta", int'(o_time_a), 5);

    // Saturation: drive A to 14 with back-to-back turns, then one more increment.
    step(0, 0, 1, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 1);
    end
    chk("sat_pre_ta", int'(o_time_a), 14);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("sat_ta", int'(o_time_a), 15);

    // Random pulses, reset rare so games run to flag fall.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 5) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/chess_clock_ctrl.md
# chess_clock_ctrl

Two-player chess-clock controller. It sequences the 1 Hz enable pulse from the Prescaler into one of two per-player countdown registers, so only the player on move consumes time. It handles the turn buttons, start/pause, optional Fischer increment and flag fall. It sits between the Prescaler (CEO → CE) and the display/decoder logic.

## Interface
- TIME_W, 12: width of each player's time register, in seconds.
- INIT_SEC, 300: time loaded for each player at reset and on NEW. Legal range 1 … 2^TIME_W−1.
- INC_SEC, 0: seconds added to the mover's clock when the mover presses their button. 0 disables the increment.

- CLK  in  1  system clock.
- CLR  in  1  reset, synchronous, active-high.
- CE  in  1  one-cycle tick from Prescaler CEO.
- START  in  1  one-cycle pulse: begin game / resume.
- PAUSE  in  1  one-cycle pulse: suspend running clock.
- NEW  in  1  one-cycle pulse: reload both times, return to IDLE.
- BTN_A, BTN_B  in  1  debounced one-cycle turn-end pulses.
- TIME_A, TIME_B  out  TIME_W  remaining seconds per player.
- ACTIVE  out  1  player on move: 0 = A, 1 = B.
- RUN  out  1  high in RUN_A / RUN_B.
- FLAG_A, FLAG_B  out  1  sticky timeout flags.

## Operation
- States: IDLE, RUN_A, RUN_B, PAUSED, OVER.
- IDLE:
  - START → RUN_A (A moves first).
  - CE, PAUSE and buttons are ignored.
- RUN_A (RUN_B is symmetric):
  - Evaluation order within one cycle:
    1. If CE is high, TIME_A decrements.
    2. If the decremented value is 0, set FLAG_A and go to OVER. PAUSE and buttons are ignored that cycle.
    3. Otherwise, PAUSE → PAUSED, with ACTIVE unchanged.
    4. Otherwise, BTN_A → RUN_B, ACTIVE = 1, and TIME_A gains INC_SEC.
  - The increment is applied to the post-decrement value and saturates at 2^TIME_W−1.
  - BTN_B is ignored in RUN_A.
  - NEW is ignored while running.
- PAUSED:
  - START → RUN_A if ACTIVE = 0, otherwise RUN_B.
  - NEW → reload and go to IDLE.
  - CE and buttons are ignored.
- OVER:
  - Times and flags are frozen.
  - NEW → reload, clear flags, go to IDLE.
  - START is ignored.
- Reload (NEW, or CLR) sets:
  - TIME_A = TIME_B = INIT_SEC;
  - ACTIVE = 0;
  - FLAG_A = FLAG_B = 0.
- Only one flag can ever be set per game.
- A time register never underflows below 0.

## Timing
- CLR is sampled on the CLK rising edge. Reset takes priority over every other input, in any state including mid-run.
- Values after CLR:
  - state = IDLE, RUN = 0, ACTIVE = 0;
  - FLAG_A = FLAG_B = 0;
  - TIME_A = TIME_B = INIT_SEC.
- All outputs are registered. The effect of any input pulse is visible on the cycle after the edge where it is sampled (latency 1).
- CE is a single-cycle pulse. Each CE sampled in RUN_x removes exactly one second.
- Back-to-back pulses on consecutive cycles are each honoured. Example: BTN_A and then BTN_B on the next cycle gives A→B→A.
- Simultaneous START and PAUSE while in PAUSED: START wins.

## Structure
- Shared package chess_clock_pkg:
  - state encoding constants (3-bit: IDLE = 0, RUN_A = 1, RUN_B = 2, PAUSED = 3, OVER = 4);
  - default TIME_W / INIT_SEC.
- Sub-module chess_timer, instantiated twice (A and B):
  - inputs: load, dec, inc;
  - parameters: INIT_SEC, INC_SEC;
  - behaviour: saturating add, zero-after-decrement detect output.
- The top level holds only the FSM, ACTIVE and the flags.

## Test plan
All scenarios use TIME_W = 4, INIT_SEC = 5, INC_SEC = 2, and CE once every 4 CLK.

- **Reset mid-run.** CLR asserted in RUN_B with TIME_B = 3 → next cycle: IDLE, TIME_A = TIME_B = 5, ACTIVE = 0, RUN = 0.
- **Basic turn.** START, 2 CE, BTN_A → TIME_A = 5 (5 − 2 + 2), ACTIVE = 1. Then 1 CE → TIME_B = 4, TIME_A unchanged.
- **Pause/resume.** In RUN_B, PAUSE, then 3 CE, then START → TIME_B unchanged during the pause; resumes in RUN_B; the next CE decrements B.
- **Simultaneous CE + BTN_A with TIME_A = 1.** → TIME_A = 0, FLAG_A = 1, OVER. The button is ignored and TIME_B is unchanged.
- **Saturation.** TIME_A = 14, BTN_A with INC_SEC = 2 → TIME_A = 15, not 0.
- **Game over and restart.** In OVER: START and BTN pulses → no change. NEW → IDLE, flags cleared, both times = 5.
